// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants and record layout for the trace arbiter
// Record layout gains a timestamp field when TRACE_TS_EN is defined.
package trace_pkg;

  localparam int NREQ_DEFAULT  = 4;
  localparam int DW_DEFAULT    = 32;
  localparam int DEPTH_DEFAULT = 4;
  localparam int SW_DEFAULT    = $clog2(NREQ_DEFAULT);

  localparam int SRC_IF = 0;
  localparam int SRC_ID = 1;
  localparam int SRC_EX = 2;
  localparam int SRC_WB = 3;

  typedef struct packed {
    logic [SW_DEFAULT-1:0] src;
    logic [DW_DEFAULT-1:0] data;
`ifdef TRACE_TS_EN
    logic [31:0]           ts;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous record FIFO with registered head storage
// Head is read straight from the storage array, so it is stable while not popped.
module trace_fifo #(
  parameter int  W     = 34,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      // Simultaneous push and pop leaves occupancy untouched, even when full.
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  assign head  = mem[rptr];
  assign valid = (level != '0);

endmodule

// File: rtl/trace_arbiter.sv
// rtl/trace_arbiter.sv - round-robin arbiter sharing one trace sink among pipeline stages
// Optional TRACE_TS_EN adds a free-running cycle counter and out_ts per record.
module trace_arbiter
  import trace_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEFAULT,
  parameter int  DW    = DW_DEFAULT,
  parameter int  DEPTH = DEPTH_DEFAULT,
  localparam int SW    = $clog2(NREQ),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_src,
`ifdef TRACE_TS_EN
  output logic [31:0]        out_ts,
`endif
  output logic [LW-1:0]      level
);

`ifdef TRACE_TS_EN
  localparam int EW = SW + DW + 32;
`else
  localparam int EW = SW + DW;
`endif

  logic [SW-1:0] rr;
  logic [SW-1:0] win;
  logic          found;
  logic          can_push;
  logic          pop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;

  assign pop      = out_valid && out_ready;
  // Gated by rst_n so no grant is issued while reset is held.
  assign can_push = rst_n && ((level < LW'(DEPTH)) || pop);

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    gnt   = '0;
    idx   = 0;
    if (can_push) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr) + k) % NREQ;
        if (!found && req[idx]) begin
          found = 1'b1;
          win   = SW'(idx);
        end
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (found) begin
      rr <= (win == SW'(NREQ - 1)) ? '0 : win + SW'(1);
    end
  end

`ifdef TRACE_TS_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end

  assign push_entry = {win, req_data[int'(win)*DW +: DW], ts_cnt};
  assign out_ts     = head[31:0];
`else
  assign push_entry = {win, req_data[int'(win)*DW +: DW]};
`endif

  assign out_src  = head[EW-1 -: SW];
  assign out_data = head[EW-SW-1 -: DW];

  trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (found),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .valid     (out_valid),
    .level     (level)
  );

endmodule

// File: tb/tb_trace_arbiter.sv
// tb/tb_trace_arbiter.sv - self-checking bench for trace_arbiter against a queue model
// Timestamp checks are compiled in when TRACE_TS_EN is defined.
module tb_trace_arbiter;
  import trace_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(NREQ);
  localparam int LW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [SW-1:0]      out_src;
  logic [LW-1:0]      level;
`ifdef TRACE_TS_EN
  logic [31:0]        out_ts;
`endif

  trace_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
`ifdef TRACE_TS_EN
    .out_ts    (out_ts),
`endif
    .level     (level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  trace_rec_t  mq[$];
  trace_rec_t  popped[$];
  int          m_rr;
  logic [31:0] m_cyc;
  int          last_win;

  typedef struct {
    logic [NREQ-1:0] req;
    logic            rdy;
    logic [NREQ-1:0] exp_gnt;
    int              exp_level;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: check DUT against the model, then advance both across the edge.
  task automatic step();
    logic [NREQ-1:0] eg;
    int              w;
    trace_rec_t      rec;
    #1;
    eg = '0;
    w  = -1;
    if (mq.size() < DEPTH || (mq.size() > 0 && out_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_rr + k) % NREQ;
        if (w < 0 && req[i]) w = i;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("level", 32'(level), 32'(mq.size()));
    if (mq.size() > 0) begin
      check("out_data", out_data, mq[0].data);
      check("out_src", 32'(out_src), 32'(mq[0].src));
`ifdef TRACE_TS_EN
      check("out_ts", out_ts, mq[0].ts);
`endif
    end
    rec = '0;
    if (w >= 0) begin
      rec.src  = SW'(w);
      rec.data = req_data[w*DW +: DW];
`ifdef TRACE_TS_EN
      rec.ts   = m_cyc;
`endif
    end
    last_win = w;
    @(posedge clk);
    if (mq.size() > 0 && out_ready) begin
      popped.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (w >= 0) begin
      mq.push_back(rec);
      m_rr = (w + 1) % NREQ;
    end
    m_cyc = m_cyc + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    mq.delete();
    m_rr  = 0;
    m_cyc = 32'd0;
  endtask

  task automatic drain();
    req       = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 2 * DEPTH && mq.size() > 0; n++) step();
    check("drain_empty", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    int   n;
    int   guard;

    vecs[0] = '{4'b0001, 1'b0, 4'b0001, 1};
    vecs[1] = '{4'b0001, 1'b0, 4'b0001, 2};
    vecs[2] = '{4'b1010, 1'b0, 4'b0010, 3};
    vecs[3] = '{4'b1010, 1'b0, 4'b1000, 4};
    vecs[4] = '{4'b1111, 1'b0, 4'b0000, 4};
    vecs[5] = '{4'b1111, 1'b1, 4'b0001, 4};
    vecs[6] = '{4'b0000, 1'b1, 4'b0000, 3};
    vecs[7] = '{4'b0100, 1'b1, 4'b0100, 3};
    vecs[8] = '{4'b0101, 1'b0, 4'b0001, 4};
    vecs[9] = '{4'b0101, 1'b0, 4'b0000, 4};

    req       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'hA0 + i;
    m_rr     = 0;
    m_cyc    = '0;
    last_win = -1;

    @(negedge clk);
    do_reset();
    check("rst_data", out_data, 32'd0);
    check("rst_src", 32'(out_src), 32'd0);

    // Table-driven sequence starting from an empty FIFO with rr=0.
    for (int v = 0; v < 10; v++) begin
      req       = vecs[v].req;
      out_ready = vecs[v].rdy;
      #1;
      check($sformatf("tbl_gnt[%0d]", v), 32'(gnt), 32'(vecs[v].exp_gnt));
      step();
      check($sformatf("tbl_level[%0d]", v), 32'(level), 32'(vecs[v].exp_level));
    end
    drain();

    // Single request from EX.
    req_data[SRC_EX*DW +: DW] = 32'hDEADBEEF;
    req       = 4'b0100;
    out_ready = 1'b1;
    #1;
    check("single_gnt", 32'(gnt), 32'(4'b0100));
    step();
    req = '0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", out_data, 32'hDEADBEEF);
    check("single_src", 32'(out_src), 32'(SRC_EX));
    drain();

    // Fill to three records, then reset mid-run with all requests held.
    req       = 4'b0001;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_level", 32'(level), 32'd3);
    req = 4'b1111;
    do_reset();

    // Fairness immediately after reset release.
    out_ready = 1'b1;
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("fair_win[%0d]", i), 32'(last_win), 32'(i % NREQ));
    end
    check("fair_popped", 32'(popped.size()), 32'd7);
    for (int i = 0; i < popped.size(); i++)
      check($sformatf("fair_sink[%0d]", i), 32'(popped[i].src), 32'(i % NREQ));
    drain();

    // Backpressure: four grants then stall, then push and pop together.
    req       = 4'b0001;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check($sformatf("bp_win[%0d]", i), 32'(last_win), 32'd0);
    end
    step();
    check("bp_stall", 32'(last_win), 32'hFFFFFFFF);
    check("bp_full", 32'(level), 32'(DEPTH));
    out_ready = 1'b1;
    step();
    check("bp_pushpop", 32'(last_win), 32'd0);
    check("bp_level", 32'(level), 32'(DEPTH));
    drain();

    // Wrap-around: ten records through requester 0 with random backpressure.
    popped.delete();
    n     = 1;
    guard = 0;
    while (n <= 10 && guard < 200) begin
      req                  = 4'b0001;
      req_data[0 +: DW]    = 32'(n);
      out_ready            = 1'($urandom_range(0, 1));
      step();
      if (last_win == 0) n++;
      guard++;
    end
    check("wrap_budget", 32'(n), 32'd11);
    drain();
    check("wrap_count", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size() && i < 10; i++)
      check($sformatf("wrap_data[%0d]", i), popped[i].data, 32'(i + 1));

`ifdef TRACE_TS_EN
    req = '0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      req = (c == 5 || c == 9) ? 4'b0001 : 4'b0000;
      step();
      if (c == 5 || c == 9) check($sformatf("ts_at_%0d", c), out_ts, 32'(c));
    end
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req       = NREQ'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
# trace_arbiter

Shares one debug trace sink (simulation log writer, or the LED/segment debug port on hardware) among up to NREQ pipeline-stage requesters (IF, ID, EX, WB). Requests are granted round-robin, records are buffered in a small FIFO, and they are presented to the sink on a valid/ready channel tagged with the source index. It sits between the CPU pipeline stages and the single trace output, so no two stages ever write the sink in the same cycle.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 32, record data width
- DEPTH, 4, FIFO depth in records (power of 2, at least 2)
- SW, $clog2(NREQ), source tag width (derived localparam)
- clk  in  1  system clock; all state is rising-edge triggered
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester record request; held high until granted
- req_data  in  NREQ*DW  flattened records; slice i is requester i's record
- gnt  out  NREQ  one-hot, combinational; record i is captured at this edge
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink accepts the head record
- out_data  out  DW  head record data
- out_src  out  SW  head record source index
- out_ts  out  32  head record timestamp (only when TRACE_TS_EN is defined)
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Round-robin pointer rr, SW bits, reset 0: the search starts at rr and wraps modulo NREQ. The first requester with req high wins.
- can_push = (level < DEPTH) || (out_valid && out_ready).
- When can_push is true and any req is high, exactly one gnt bit is high. Otherwise gnt = 0.
- On a grant to i: push {i, req_data slice i} and set rr = (i+1) mod NREQ. rr is unchanged when nothing is granted.
- A requester that holds req after its grant offers its next record. It cannot win again while others are requesting, because of the rotation.
- Pop happens when out_valid && out_ready. out_valid = (level != 0).
- out_data and out_src are driven from FIFO head storage. They are stable while out_valid is high and out_ready is low.
- Push and pop in the same cycle leave level unchanged. This holds even when full, so the grant still occurs.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Records are never dropped or reordered. Sink order equals grant order.

## Timing
- Reset values: gnt = 0, out_valid = 0, out_data = 0, out_src = 0, out_ts = 0, level = 0, rr = 0, pointers = 0.
- gnt depends combinationally on req, rr and level/out_ready in the same cycle. There is no combinational path from req to out_*.
- Grant-to-out_valid latency is 1 cycle, measured from the grant edge into an empty FIFO.
- Sustained throughput is one record per cycle while out_ready stays high.
- When full and out_ready is low, gnt = 0 and req is held by the requesters (backpressure).
- Reset asserted mid-operation clears the FIFO immediately and discards buffered records. Requesters re-request after reset.

## Configuration
- TRACE_TS_EN defined:
  - A free-running 32-bit cycle counter (reset 0, wraps at 2^32) is added.
  - Each FIFO entry also stores the counter value at the grant edge.
  - That value is presented on out_ts with the head record.
- TRACE_TS_EN undefined:
  - The counter, the timestamp storage and the out_ts port are all absent.
  - Every other behaviour is identical.

## Structure
- Shared package trace_pkg holds:
  - the default NREQ, DW and DEPTH constants;
  - source index localparams SRC_IF=0, SRC_ID=1, SRC_EX=2, SRC_WB=3;
  - the record typedef {src, data[, ts]}.
- One sub-module, trace_fifo: a synchronous FIFO with push/pop/level and a registered head. The arbiter and pointer logic stay in trace_arbiter.

## Test plan
- Reset: assert rst_n=0 mid-run with level=3 -> out_valid=0, level=0, gnt=0 while rst_n is low. After release, the first grant goes to requester 0.
- Single request: req=4'b0100 with data 0xDEADBEEF, out_ready=1 -> gnt=4'b0100 in that cycle. One cycle later out_valid=1, out_data=0xDEADBEEF, out_src=2.
- Fairness: req=4'b1111 held for 8 cycles, out_ready=1 -> grant sequence 0,1,2,3,0,1,2,3, and the sink sees the same out_src order.
- Backpressure: out_ready=0, req=4'b0001 held -> 4 grants, then level=4 and gnt=0. Raising out_ready=1 -> a push and a pop in the same cycle, level stays 4.
- Wrap-around: push/pop 10 records 0x1..0xA through DEPTH=4 with random out_ready -> output is 0x1..0xA in order, with no loss or duplicates.
- TRACE_TS_EN: grants at cycles 5 and 9 after reset release -> out_ts=5 and out_ts=9 with the respective records. The build without the macro has no out_ts port.
